// File: rtl/cpc_fifo_host_ctrl.sv
// Host-side CPC Z80 bus controller for the cpc_fifo board: decodes the data/status
// ports and generates the 74HCT40105 shift-in/shift-out/reset handshakes.
module cpc_fifo_host_ctrl #(
    parameter logic [15:0] BASE_ADDR  = 16'hFD80,
    parameter logic [15:0] ADDR_MASK  = 16'hFFF2,
    parameter int unsigned SI_CYCLES  = 2,
    parameter int unsigned SO_CYCLES  = 2,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        M1_B,
    input  logic        fifo_host_dir,
    input  logic        fifo_host_dor,
    output logic        host_fifo_si,
    output logic        host_fifo_sob,
    output logic        host_fifo_oeb,
    output logic        host_fifo_reset
);

    typedef enum logic [2:0] {
        IDLE, SI_PULSE, RD_DATA, SO_PULSE, RD_STAT, MR_PULSE, WAIT_END
    } state_t;

    localparam logic [3:0] SI_LOAD  = 4'(SI_CYCLES - 1);
    localparam logic [3:0] SO_LOAD  = 4'(SO_CYCLES - 1);
    localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES - 1);
    // The reset-entry load is one longer because the cycles spent with RESET high
    // are not part of the post-reset stretch.
    localparam logic [3:0] RST_INIT = 4'(RST_CYCLES);

    logic        ioreq_s, rd_s, wr_s, m1_s, d7_s;
    logic [15:0] a_s;
    logic        dir_m, dir_s, dor_m, dor_s;
    state_t      state;
    logic [3:0]  cnt;
    logic        from_reset, had_data, ovf, unf;
    logic        addr_hit, acc;
    logic [7:0]  status;
    logic        unused_d_in;

    assign unused_d_in = &{1'b0, D_IN[6:0]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ioreq_s <= 1'b1;
            rd_s    <= 1'b1;
            wr_s    <= 1'b1;
            m1_s    <= 1'b1;
            d7_s    <= 1'b0;
            a_s     <= '0;
            dir_m   <= 1'b0;
            dir_s   <= 1'b0;
            dor_m   <= 1'b0;
            dor_s   <= 1'b0;
        end else begin
            ioreq_s <= IOREQ_B;
            rd_s    <= RD_B;
            wr_s    <= WR_B;
            m1_s    <= M1_B;
            d7_s    <= D_IN[7];
            a_s     <= A;
            dir_m   <= fifo_host_dir;
            dir_s   <= dir_m;
            dor_m   <= fifo_host_dor;
            dor_s   <= dor_m;
        end
    end

    always_comb begin
        addr_hit = (a_s & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
        acc      = !ioreq_s && m1_s && addr_hit;
        status   = {ovf, unf, 4'b0000, dir_s, dor_s};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= MR_PULSE;
            cnt             <= RST_INIT;
            from_reset      <= 1'b1;
            had_data        <= 1'b0;
            ovf             <= 1'b0;
            unf             <= 1'b0;
            host_fifo_si    <= 1'b0;
            host_fifo_sob   <= 1'b1;
            host_fifo_oeb   <= 1'b1;
            host_fifo_reset <= 1'b1;
            D_OE            <= 1'b0;
            D_OUT           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (!rd_s && !wr_s) begin
                            state <= WAIT_END;
                        end else if (!wr_s) begin
                            if (!a_s[0]) begin
                                if (dir_s) begin
                                    host_fifo_si <= 1'b1;
                                    cnt          <= SI_LOAD;
                                    state        <= SI_PULSE;
                                end else begin
                                    ovf   <= 1'b1;
                                    state <= WAIT_END;
                                end
                            end else if (d7_s) begin
                                host_fifo_reset <= 1'b1;
                                cnt             <= RST_LOAD;
                                from_reset      <= 1'b0;
                                ovf             <= 1'b0;
                                unf             <= 1'b0;
                                state           <= MR_PULSE;
                            end else begin
                                state <= WAIT_END;
                            end
                        end else if (!rd_s) begin
                            if (!a_s[0]) begin
                                host_fifo_oeb <= 1'b0;
                                had_data      <= dor_s;
                                state         <= RD_DATA;
                            end else begin
                                D_OE  <= 1'b1;
                                D_OUT <= status;
                                state <= RD_STAT;
                            end
                        end
                    end
                end
                SI_PULSE: begin
                    if (cnt == '0) begin
                        host_fifo_si <= 1'b0;
                        state        <= WAIT_END;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_DATA: begin
                    if (rd_s) begin
                        host_fifo_oeb <= 1'b1;
                        if (had_data) begin
                            host_fifo_sob <= 1'b0;
                            cnt           <= SO_LOAD;
                            state         <= SO_PULSE;
                        end else begin
                            unf   <= 1'b1;
                            state <= WAIT_END;
                        end
                    end
                end
                SO_PULSE: begin
                    if (cnt == '0) begin
                        host_fifo_sob <= 1'b1;
                        state         <= WAIT_END;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_STAT: begin
                    if (!rd_s) begin
                        D_OUT <= status;
                    end else begin
                        D_OE  <= 1'b0;
                        D_OUT <= '0;
                        ovf   <= 1'b0;
                        unf   <= 1'b0;
                        state <= WAIT_END;
                    end
                end
                MR_PULSE: begin
                    ovf <= 1'b0;
                    unf <= 1'b0;
                    if (cnt == '0) begin
                        host_fifo_reset <= 1'b0;
                        from_reset      <= 1'b0;
                        state           <= from_reset ? IDLE : WAIT_END;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WAIT_END: begin
                    if (ioreq_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
